nn_layer_sequencer: RTL and testbench

//  Control FSM that drives a full multi-layer inference through the accelerator/shift_reg_mem pair.

---
 rtl/nn_layer_sequencer.sv | 144 ++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// Control FSM sequencing a multi-layer inference through the accelerator and
// shift_reg_mem: load ifmap, then per layer clear / 32 MAC steps / write-back.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             inference request, only honoured while idle
//   weight_valid      weight row for weight_row_addr present this cycle
//   busy, done        status; done is a one-cycle pulse at the end of a run
//   layer_idx         current layer (0-based)
//   mem_addr          shift_reg_mem read address (current step)
//   weight_row_addr   {layer_idx, step} index into the weight store
//   acc_enable        MAC this cycle (RUN and weight_valid)
//   acc_clear         clear the accumulators
//   mem_write_enable  shift_reg_mem write strobe
//   ifmap_sel         1: write external ifmap, 0: write back output_fmap
module nn_layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int VEC_LEN    = 32,
  parameter int ADDR_W     = 5,
  parameter int LAYER_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      weight_valid,
  output logic                      busy,
  output logic                      done,
  output logic [LAYER_W-1:0]        layer_idx,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LAYER_W+ADDR_W-1:0] weight_row_addr,
  output logic                      acc_enable,
  output logic                      acc_clear,
  output logic                      mem_write_enable,
  output logic                      ifmap_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0]  LAST_STEP  = ADDR_W'(VEC_LEN - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_t               state;
  logic [LAYER_W-1:0]   layer_q;
  logic [ADDR_W-1:0]    step_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 mwe_q;
  logic                 ifsel_q;
  logic                 clr_q;
  logic                 run_q;

  // Strobes are registered alongside the state: each branch sets the
  // outputs that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      layer_q <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mwe_q   <= 1'b0;
      ifsel_q <= 1'b0;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      mwe_q   <= 1'b0;
      ifsel_q <= 1'b0;
      clr_q   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD;
            busy_q  <= 1'b1;
            mwe_q   <= 1'b1;
            ifsel_q <= 1'b1;
          end
        end
        S_LOAD: begin
          state <= S_CLEAR;
          clr_q <= 1'b1;
        end
        S_CLEAR: begin
          state  <= S_RUN;
          step_q <= '0;
          run_q  <= 1'b1;
        end
        S_RUN: begin
          // A missing weight row stalls the whole datapath in place.
          if (weight_valid) begin
            if (step_q == LAST_STEP) begin
              state <= S_WB;
              run_q <= 1'b0;
              mwe_q <= 1'b1;
            end else begin
              step_q <= step_q + ADDR_W'(1);
            end
          end
        end
        S_WB: begin
          if (layer_q == LAST_LAYER) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            state   <= S_CLEAR;
            layer_q <= layer_q + LAYER_W'(1);
            clr_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          layer_q <= '0;
          step_q  <= '0;
        end
        default: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          run_q   <= 1'b0;
          layer_q <= '0;
          step_q  <= '0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign layer_idx        = layer_q;
  assign mem_addr         = step_q;
  assign weight_row_addr  = {layer_q, step_q};
  assign acc_enable       = run_q & weight_valid;
  assign acc_clear        = clr_q;
  assign mem_write_enable = mwe_q;
  assign ifmap_sel        = ifsel_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: flattened-program reference model compared
// every cycle, plus directed runs with literal timing/count expectations.
module tb_nn_layer_sequencer;

  localparam int NL = 4;
  localparam int VL = 32;
  localparam int AW = 5;
  localparam int LW = 2;

  localparam int OP_LOAD  = 0;
  localparam int OP_CLEAR = 1;
  localparam int OP_RUN   = 2;
  localparam int OP_WB    = 3;
  localparam int OP_DONE  = 4;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic weight_valid;
  logic busy;
  logic done;
  logic [LW-1:0] layer_idx;
  logic [AW-1:0] mem_addr;
  logic [LW+AW-1:0] weight_row_addr;
  logic acc_enable;
  logic acc_clear;
  logic mem_write_enable;
  logic ifmap_sel;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  nn_layer_sequencer #(
    .NUM_LAYERS(NL),
    .VEC_LEN(VL),
    .ADDR_W(AW),
    .LAYER_W(LW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .weight_valid(weight_valid),
    .busy(busy),
    .done(done),
    .layer_idx(layer_idx),
    .mem_addr(mem_addr),
    .weight_row_addr(weight_row_addr),
    .acc_enable(acc_enable),
    .acc_clear(acc_clear),
    .mem_write_enable(mem_write_enable),
    .ifmap_sel(ifmap_sel)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an inference is a flat list of operations; the model
  // walks it, pausing on RUN ops while no weight row is present.
  int op_kind[$];
  int op_layer[$];
  int op_step[$];
  bit m_act = 1'b0;
  int m_ptr = 0;

  function automatic void add_op(int k, int l, int s);
    op_kind.push_back(k);
    op_layer.push_back(l);
    op_step.push_back(s);
  endfunction

  function automatic void build_ops();
    add_op(OP_LOAD, 0, 0);
    for (int l = 0; l < NL; l++) begin
      add_op(OP_CLEAR, l, (l == 0) ? 0 : VL - 1);
      for (int s = 0; s < VL; s++) add_op(OP_RUN, l, s);
      add_op(OP_WB, l, VL - 1);
    end
    add_op(OP_DONE, NL - 1, VL - 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act <= 1'b1;
        m_ptr <= 0;
      end
    end else if (op_kind[m_ptr] == OP_RUN && !weight_valid) begin
      m_ptr <= m_ptr;
    end else if (m_ptr == op_kind.size() - 1) begin
      m_act <= 1'b0;
    end else begin
      m_ptr <= m_ptr + 1;
    end
  end

  always @(negedge clk) begin
    int k;
    int el;
    int es;
    if (chk_en) begin
      k  = m_act ? op_kind[m_ptr] : -1;
      el = m_act ? op_layer[m_ptr] : 0;
      es = m_act ? op_step[m_ptr] : 0;
      cmp("busy", busy, m_act);
      cmp("done", done, k == OP_DONE);
      cmp("mem_write_enable", mem_write_enable, k == OP_LOAD || k == OP_WB);
      cmp("ifmap_sel", ifmap_sel, k == OP_LOAD);
      cmp("acc_clear", acc_clear, k == OP_CLEAR);
      cmp("acc_enable", acc_enable, k == OP_RUN && weight_valid);
      cmp("layer_idx", layer_idx, el);
      cmp("mem_addr", mem_addr, es);
      cmp("weight_row_addr", weight_row_addr, el * VL + es);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int r_done_cyc;
  int r_ndone;
  int r_nmwe;
  int r_mwe_sum;
  int r_naen;
  int r_nclr;
  int r_wra;
  int r_ma;
  int r_ifs;
  int r_wb;
  int r_stall_bad;
  int r_stall_seen;
  int r_rst_nz;

  // One inference from a start pulse; observes 180 cycles (no-stall run
  // finishes at 138, so a run that never completes shows done_cyc=-1).
  task automatic run_seq(input int stall_at, input int stall_len,
                         input int pulse_at, input int reset_at);
    r_done_cyc = -1;
    r_ndone = 0; r_nmwe = 0; r_mwe_sum = 0; r_naen = 0; r_nclr = 0;
    r_wra = -1; r_ma = -1; r_ifs = -1; r_wb = -1;
    r_stall_bad = 0; r_stall_seen = 0; r_rst_nz = -1;
    start = 1'b1;
    weight_valid = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 180; cyc++) begin
      bit in_stall;
      in_stall = stall_len > 0 && cyc >= stall_at &&
                 cyc < stall_at + stall_len;
      weight_valid = !in_stall;
      start = (cyc == pulse_at);
      reset = (cyc == reset_at);
      @(negedge clk);
      if (done) begin
        r_ndone++;
        if (r_done_cyc < 0) r_done_cyc = cyc;
      end
      if (mem_write_enable) begin
        r_nmwe++;
        r_mwe_sum += cyc;
      end
      if (acc_enable) r_naen++;
      if (acc_clear) r_nclr++;
      if (cyc == 102) begin
        r_wra = int'(weight_row_addr);
        r_ma = int'(mem_addr);
      end
      if (cyc == 103) begin
        r_ifs = int'(ifmap_sel);
        r_wb = int'(mem_write_enable);
      end
      if (in_stall) begin
        r_stall_seen++;
        if (mem_addr != 10 || layer_idx != 1 || acc_enable) r_stall_bad++;
      end
      if (reset_at > 0 && cyc == reset_at + 1)
        r_rst_nz = int'({busy, done, acc_enable, acc_clear,
                         mem_write_enable, ifmap_sel} != 0) +
                   int'(mem_addr) + int'(weight_row_addr) + int'(layer_idx);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    weight_valid = 1'b1;
  endtask

  initial begin
    build_ops();
    reset = 1'b1;
    start = 1'b1;
    weight_valid = 1'b1;

    // Reset held with start high: everything quiet.
    tick();
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp("rst_busy", busy, 0);
      cmp("rst_mwe", mem_write_enable, 0);
      tick();
    end
    reset = 1'b0;
    tick();
    @(negedge clk);
    cmp("post_rst_load_mwe", mem_write_enable, 1);
    cmp("post_rst_load_ifsel", ifmap_sel, 1);
    cmp("post_rst_load_busy", busy, 1);
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Plain run, weight rows always present.
    run_seq(0, 0, 0, 0);
    cmp("t2_done_cycle", r_done_cyc, 138);
    cmp("t2_done_count", r_ndone, 1);
    cmp("t2_mwe_count", r_nmwe, 5);
    cmp("t2_mwe_cycle_sum", r_mwe_sum, 1 + 35 + 69 + 103 + 137);
    cmp("t2_acc_en_count", r_naen, 128);
    cmp("t2_acc_clr_count", r_nclr, 4);
    cmp("t4_wra_l2s31", r_wra, 95);
    cmp("t4_ma_l2s31", r_ma, 31);
    cmp("t4_wb_ifsel", r_ifs, 0);
    cmp("t4_wb_mwe", r_wb, 1);

    // Three-cycle stall at layer 1 step 10 (cycle 47).
    run_seq(47, 3, 0, 0);
    cmp("t3_done_cycle", r_done_cyc, 141);
    cmp("t3_stall_seen", r_stall_seen, 3);
    cmp("t3_stall_bad", r_stall_bad, 0);
    cmp("t3_acc_en_count", r_naen, 128);

    // start pulsed mid-run is ignored.
    run_seq(0, 0, 50, 0);
    cmp("t5_done_cycle", r_done_cyc, 138);
    cmp("t5_done_count", r_ndone, 1);
    cmp("t5_mwe_count", r_nmwe, 5);

    // start held high: done, one idle cycle, LOAD again.
    start = 1'b1;
    weight_valid = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 140; cyc++) begin
      @(negedge clk);
      if (cyc == 138) cmp("t5h_done", done, 1);
      if (cyc == 139) cmp("t5h_idle_busy", busy, 0);
      if (cyc == 140) begin
        cmp("t5h_reload_mwe", mem_write_enable, 1);
        cmp("t5h_reload_ifsel", ifmap_sel, 1);
      end
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Reset at layer 2 step 5 (cycle 76), then a fresh run.
    run_seq(0, 0, 0, 76);
    cmp("t6_outputs_zero", r_rst_nz, 0);
    cmp("t6_no_done", r_ndone, 0);
    run_seq(0, 0, 0, 0);
    cmp("t6_fresh_done_cycle", r_done_cyc, 138);
    cmp("t6_fresh_done_count", r_ndone, 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
